// File: rtl/hidden_cpu_pkg.sv
// Shared definitions for the HiddenCPU second-generation core:
// opcodes, SYS subcodes, FSM states and a width helper.
package hidden_cpu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;
  localparam logic [2:0] OP_LD  = 3'd5;
  localparam logic [2:0] OP_ST  = 3'd6;
  localparam logic [2:0] OP_SYS = 3'd7;

  localparam logic [1:0] SYS_BCS = 2'd0;
  localparam logic [1:0] SYS_TOG = 2'd1;
  localparam logic [1:0] SYS_CLC = 2'd2;
  localparam logic [1:0] SYS_NOP = 2'd3;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_EXEC      = 2'd1,
    ST_LOAD_WAIT = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/hidden_cpu_alu.sv
// Combinational ALU for the register-to-register opcodes.
// Only ADD and SUB request a carry-flag update.
module hidden_cpu_alu
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry_new,
  output logic              carry_we
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum       = '0;
    result    = '0;
    carry_new = 1'b0;
    carry_we  = 1'b0;
    unique case (op)
      OP_ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        result    = sum[DATA_W-1:0];
        carry_new = sum[DATA_W];
        carry_we  = 1'b1;
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow (a < b)
        sum       = {1'b0, a} - {1'b0, b};
        result    = sum[DATA_W-1:0];
        carry_new = sum[DATA_W];
        carry_we  = 1'b1;
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = b;
      default: ;
    endcase
  end

endmodule

// File: rtl/hidden_cpu_core.sv
// HiddenCPU execution core: register file, data RAM, PC and the
// CLEAR / EXEC / LOAD_WAIT sequencer around a combinational ALU.
module hidden_cpu_core
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 4,
  parameter int RAM_DEPTH = 16,
  parameter int PC_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            instr_valid,
  output logic                            instr_ready,
  input  logic [3+2*clog2(NUM_REGS)-1:0]  instr,
  output logic [DATA_W-1:0]               out_data,
  output logic [PC_W-1:0]                 pc_out,
  output logic                            carry_out
);

  localparam int RA_W = clog2(NUM_REGS);
  localparam int AW   = clog2(RAM_DEPTH);
  localparam int IW   = 3 + 2 * RA_W;
  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t state, nextState;

  logic [DATA_W-1:0] r   [NUM_REGS];
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic [PC_W-1:0]   pc;
  logic              c;
  logic              sel;
  logic [AW-1:0]     clrAddr;
  logic [RA_W-1:0]   ldReg;
  logic [AW-1:0]     ldAddr;

  logic [2:0]        op;
  logic [RA_W-1:0]   ra, rb;
  logic [1:0]        sub;
  logic [DATA_W-1:0] a, b;
  logic [AW-1:0]     memAddr;
  logic              accept;
  logic              isAlu, isLd, isSt, isSys;
  logic              take;
  logic [PC_W-1:0]   aPc, pcStep;
  logic [DATA_W-1:0] pcData;
  logic [DATA_W-1:0] aluRes;
  logic              aluCarry, aluCarryWe;

  assign op      = instr[IW-1 -: 3];
  assign ra      = instr[2*RA_W-1 -: RA_W];
  assign rb      = instr[RA_W-1:0];
  assign sub     = rb[1:0];
  assign a       = r[ra];
  assign b       = r[rb];
  assign memAddr = b[AW-1:0];
  assign accept  = instr_valid & instr_ready;

  assign isAlu = (op <= OP_MOV);
  assign isLd  = (op == OP_LD);
  assign isSt  = (op == OP_ST);
  assign isSys = (op == OP_SYS);
  assign take  = isSys & (sub == SYS_BCS) & c;

  generate
    if (PC_W <= DATA_W) begin : gA2Pc
      assign aPc = a[PC_W-1:0];
    end else begin : gA2PcExt
      assign aPc = {{(PC_W-DATA_W){1'b0}}, a};
    end
    if (DATA_W <= PC_W) begin : gPc2D
      assign pcData = pc[DATA_W-1:0];
    end else begin : gPc2DExt
      assign pcData = {{(DATA_W-PC_W){1'b0}}, pc};
    end
  endgenerate

  assign pcStep    = take ? aPc : PC_ONE;
  assign pc_out    = pc;
  assign carry_out = c;
  assign out_data  = sel ? pcData : r[NUM_REGS-1];

  hidden_cpu_alu #(.DATA_W(DATA_W)) uAlu (
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (aluRes),
    .carry_new (aluCarry),
    .carry_we  (aluCarryWe)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= nextState;
  end

  always_comb begin
    nextState   = state;
    instr_ready = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        if (clrAddr == AW'(RAM_DEPTH - 1)) nextState = ST_EXEC;
      end
      ST_EXEC: begin
        instr_ready = 1'b1;
        if (instr_valid && isLd) nextState = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: nextState = ST_EXEC;
      default:      nextState = ST_EXEC;
    endcase
  end

  // RAM has no reset; the CLEAR sweep zeroes it after every reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR)  ram[clrAddr] <= '0;
      else if (accept && isSt) ram[memAddr] <= a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clrAddr <= '0;
      pc      <= '0;
      c       <= 1'b0;
      sel     <= 1'b0;
      ldReg   <= '0;
      ldAddr  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r[i] <= DATA_W'(i);
    end else begin
      if (state == ST_CLEAR) clrAddr <= clrAddr + AW'(1);
      if (state == ST_LOAD_WAIT) r[ldReg] <= ram[ldAddr];
      if (accept) begin
        pc <= pc + pcStep;
        unique case (1'b1)
          isAlu: begin
            r[ra] <= aluRes;
            if (aluCarryWe) c <= aluCarry;
          end
          isLd: begin
            ldReg  <= ra;
            ldAddr <= memAddr;
          end
          isSys: begin
            if (sub == SYS_TOG) sel <= ~sel;
            if (sub == SYS_CLC) c <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hidden_cpu_core.sv
// Self-checking bench for hidden_cpu_core: directed scenarios plus
// random instruction streams against an architectural model.
module tb_hidden_cpu_core;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [6:0] instr;
  logic [7:0] out_data;
  logic [7:0] pc_out;
  logic       carry_out;

  int errors;
  int checks;

  int mr[4];
  int mram[16];
  int mpc, mc, msel;

  hidden_cpu_core #(
    .DATA_W(8), .NUM_REGS(4), .RAM_DEPTH(16), .PC_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .out_data    (out_data),
    .pc_out      (pc_out),
    .carry_out   (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mr[i] = i;
    for (int i = 0; i < 16; i++) mram[i] = 0;
    mpc = 0; mc = 0; msel = 0;
  endfunction

  function automatic void model_exec(int op, int ra, int rb);
    int av, bv, npc;
    av = mr[ra]; bv = mr[rb];
    npc = (mpc + 1) % 256;
    case (op)
      0: begin mc = ((av + bv) > 255) ? 1 : 0; mr[ra] = (av + bv) % 256; end
      1: begin mc = (av < bv) ? 1 : 0; mr[ra] = (av - bv + 256) % 256; end
      2: mr[ra] = av & bv;
      3: mr[ra] = av ^ bv;
      4: mr[ra] = bv;
      5: mr[ra] = mram[bv % 16];
      6: mram[bv % 16] = av;
      default: begin
        case (rb % 4)
          0: if (mc != 0) npc = (mpc + av) % 256;
          1: msel = (msel != 0) ? 0 : 1;
          2: mc = 0;
          default: ;
        endcase
      end
    endcase
    mpc = npc;
  endfunction

  function automatic int model_out();
    return (msel != 0) ? mpc : mr[3];
  endfunction

  task automatic do_reset(output int cnt);
    rst = 1'b1; instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cnt = 0;
    while (instr_ready !== 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    if (cnt >= 40) begin
      checks++; errors++;
      $display("FAIL reset_timeout: ready never rose after %0d cycles", cnt);
    end
  endtask

  task automatic issue(input int op, input int ra, input int rb);
    instr = {op[2:0], ra[1:0], rb[1:0]};
    instr_valid = 1'b1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL ready_exec: got %b want 1", instr_ready);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    model_exec(op, ra, rb);
    if (op == 5) begin
      checks++;
      if (instr_ready !== 1'b0) begin
        errors++; $display("FAIL ld_stall: ready got %b want 0", instr_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (instr_ready !== 1'b1) begin
        errors++; $display("FAIL ld_resume: ready got %b want 1", instr_ready);
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    do_reset(cnt);
    checks++;
    if (cnt != 16) begin
      errors++; $display("FAIL clear_len: got %0d want 16", cnt);
    end
    checks++;
    if (pc_out !== 8'h00 || carry_out !== 1'b0 || out_data !== 8'h03) begin
      errors++;
      $display("FAIL reset_state: pc=%h c=%b out=%h want 00 0 03", pc_out, carry_out, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      issue(4, 3, i);
      checks++;
      if (out_data !== 8'(i)) begin
        errors++; $display("FAIL reset_reg%0d: got %h want %h", i, out_data, i);
      end
    end
  endtask

  task automatic test_alu_carry();
    int cnt;
    do_reset(cnt);
    issue(1, 0, 1);
    checks++;
    if (carry_out !== 1'b1 || pc_out !== 8'd1) begin
      errors++; $display("FAIL sub_borrow: c=%b pc=%h want 1 01", carry_out, pc_out);
    end
    issue(0, 3, 3);
    checks++;
    if (out_data !== 8'd6 || carry_out !== 1'b0 || pc_out !== 8'd2) begin
      errors++;
      $display("FAIL add_clear: out=%h c=%b pc=%h want 06 0 02", out_data, carry_out, pc_out);
    end
    issue(4, 3, 0);
    checks++;
    if (out_data !== 8'hFF) begin
      errors++; $display("FAIL sub_result: got %h want ff", out_data);
    end
  endtask

  task automatic test_branch();
    int cnt;
    do_reset(cnt);
    issue(1, 0, 1);
    issue(7, 3, 0);
    checks++;
    if (pc_out !== 8'd4) begin
      errors++; $display("FAIL bcs_taken: pc got %h want 04", pc_out);
    end
    issue(7, 0, 2);
    checks++;
    if (carry_out !== 1'b0 || pc_out !== 8'd5) begin
      errors++; $display("FAIL clc: c=%b pc=%h want 0 05", carry_out, pc_out);
    end
    issue(7, 3, 0);
    checks++;
    if (pc_out !== 8'd6) begin
      errors++; $display("FAIL bcs_not_taken: pc got %h want 06", pc_out);
    end
  endtask

  task automatic test_load_store();
    int cnt;
    do_reset(cnt);
    issue(6, 3, 2);
    issue(5, 0, 2);
    checks++;
    if (pc_out !== 8'd2) begin
      errors++; $display("FAIL ld_pc: got %h want 02", pc_out);
    end
    issue(4, 3, 0);
    checks++;
    if (out_data !== 8'd3) begin
      errors++; $display("FAIL st_ld: got %h want 03", out_data);
    end
    for (int i = 0; i < 4; i++) issue(0, 1, 1);
    issue(0, 1, 3);
    issue(5, 1, 1);
    issue(4, 3, 1);
    checks++;
    if (out_data !== 8'd0 || out_data !== 8'(model_out())) begin
      errors++; $display("FAIL ld_wrap: got %h want 00", out_data);
    end
  endtask

  task automatic test_out_select();
    int cnt;
    logic [7:0] pcHold;
    do_reset(cnt);
    issue(0, 3, 3);
    issue(0, 2, 3);
    issue(7, 0, 1);
    checks++;
    if (out_data !== pc_out || out_data !== 8'(model_out())) begin
      errors++; $display("FAIL tog_pc: got %h want %h", out_data, model_out());
    end
    pcHold = 8'(mpc);
    for (int i = 0; i < 5; i++) begin
      instr = 7'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (pc_out !== pcHold || out_data !== pcHold) begin
      errors++; $display("FAIL idle_hold: pc=%h out=%h want %h", pc_out, out_data, pcHold);
    end
    issue(7, 2, 1);
    checks++;
    if (out_data !== 8'(mr[3])) begin
      errors++; $display("FAIL tog_back: got %h want %h", out_data, mr[3]);
    end
  endtask

  task automatic test_reset_mid_load();
    int cnt;
    do_reset(cnt);
    issue(6, 3, 2);
    instr = {3'd5, 2'd0, 2'd2};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ld_wait: ready got %b want 0", instr_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cnt = 0;
    while (instr_ready !== 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 16) begin
      errors++; $display("FAIL mid_clear_len: got %0d want 16", cnt);
    end
    issue(4, 3, 0);
    checks++;
    if (out_data !== 8'd0) begin
      errors++; $display("FAIL mid_r0: got %h want 00", out_data);
    end
    issue(5, 1, 2);
    issue(4, 3, 1);
    checks++;
    if (out_data !== 8'd0) begin
      errors++; $display("FAIL mid_ram_cleared: got %h want 00", out_data);
    end
  endtask

  task automatic test_random();
    int cnt;
    do_reset(cnt);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        instr = 7'($urandom);
        @(posedge clk); #1;
      end
      issue($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
      checks++;
      if (pc_out !== 8'(mpc) || carry_out !== mc[0] || out_data !== 8'(model_out())) begin
        errors++;
        $display("FAIL rand_%0d: pc=%h c=%b out=%h want %h %0d %h",
                 n, pc_out, carry_out, out_data, mpc, mc, model_out());
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu_carry();
    test_branch();
    test_load_store();
    test_out_select();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
